// File: rtl/ex_mem_stage_if.sv
// Beat, handshake, redirect and forwarding signals between the ALU, the EX/MEM stage and MEM.
// The slave modport is the stage itself; the master modport is its surrounding pipeline.
interface ex_mem_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     alu_result;
  logic                  alu_zero;
  logic                  alu_cout;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic                  reg_write;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_W-1:0]     store_data;
  logic [1:0]            branch_type;
  logic [DATA_W-1:0]     branch_target;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_result;
  logic                  out_zero;
  logic                  out_cout;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_reg_write;
  logic                  out_mem_read;
  logic                  out_mem_write;
  logic [DATA_W-1:0]     out_store_data;
  logic                  redirect_valid;
  logic [DATA_W-1:0]     redirect_pc;
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_rd;
  logic [DATA_W-1:0]     fwd_data;

  modport master (
    output in_valid, alu_result, alu_zero, alu_cout, rd_addr, reg_write, mem_read,
           mem_write, store_data, branch_type, branch_target, flush, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_cout, out_rd, out_reg_write,
           out_mem_read, out_mem_write, out_store_data, redirect_valid, redirect_pc,
           fwd_valid, fwd_rd, fwd_data
  );

  modport slave (
    input  in_valid, alu_result, alu_zero, alu_cout, rd_addr, reg_write, mem_read,
           mem_write, store_data, branch_type, branch_target, flush, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_cout, out_rd, out_reg_write,
           out_mem_read, out_mem_write, out_store_data, redirect_valid, redirect_pc,
           fwd_valid, fwd_rd, fwd_data
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with 2-entry skid buffer, branch resolution and forwarding bus.
// Data entries carry no reset; every visible field is qualified by its valid bit.
module ex_mem_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    ex_mem_stage_if.slave  bus
);

    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic                  zero;
        logic                  cout;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic [DATA_W-1:0]     store_data;
    } beat_t;

    beat_t             beat_p0, main_p1, skid_p1, shown_p1;
    logic              vld_p1, skid_vld_p1, in_ready_p1, redirect_vld_p1;
    logic [DATA_W-1:0] redirect_pc_p1;
    logic              accept_p0, keep_p0, taken_p0, xfer_p1;
    logic              load_main_in, load_main_skid, load_skid;

    // Stage p0: incoming ALU beat, branch resolution, entry steering
    always_comb begin
        beat_p0            = '0;
        beat_p0.result     = bus.alu_result;
        beat_p0.zero       = bus.alu_zero;
        beat_p0.cout       = bus.alu_cout;
        beat_p0.rd         = bus.rd_addr;
        beat_p0.reg_write  = bus.reg_write;
        beat_p0.mem_read   = bus.mem_read;
        beat_p0.mem_write  = bus.mem_write;
        beat_p0.store_data = bus.store_data;

        taken_p0  = ((bus.branch_type == 2'b01) &&  bus.alu_zero) ||
                    ((bus.branch_type == 2'b10) && !bus.alu_zero) ||
                     (bus.branch_type == 2'b11);
        accept_p0 = bus.in_valid & in_ready_p1 & ~bus.flush;
        // A beat arriving alongside the redirect pulse is on the wrong path.
        keep_p0   = accept_p0 & ~redirect_vld_p1;
        xfer_p1   = vld_p1 & bus.out_ready;

        load_main_skid = skid_vld_p1 & xfer_p1 & ~bus.flush;
        load_main_in   = keep_p0 & ~skid_vld_p1 & (~vld_p1 | xfer_p1);
        load_skid      = keep_p0 & vld_p1 & ~xfer_p1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1          <= 1'b0;
            skid_vld_p1     <= 1'b0;
            in_ready_p1     <= 1'b1;
            redirect_vld_p1 <= 1'b0;
        end else if (bus.flush) begin
            vld_p1          <= 1'b0;
            skid_vld_p1     <= 1'b0;
            in_ready_p1     <= 1'b1;
            redirect_vld_p1 <= 1'b0;
        end else begin
            if (load_main_in || load_main_skid) vld_p1 <= 1'b1;
            else if (xfer_p1)                   vld_p1 <= 1'b0;
            if (load_skid)           skid_vld_p1 <= 1'b1;
            else if (load_main_skid) skid_vld_p1 <= 1'b0;
            in_ready_p1     <= ~(load_skid | (skid_vld_p1 & ~xfer_p1));
            redirect_vld_p1 <= keep_p0 & taken_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (load_main_skid)    main_p1 <= skid_p1;
        else if (load_main_in) main_p1 <= beat_p0;
        if (load_skid)         skid_p1 <= beat_p0;
        if (keep_p0 && taken_p0) redirect_pc_p1 <= bus.branch_target;
    end

    // Stage p1: held main entry toward MEM, redirect and forwarding
    always_comb begin
        shown_p1 = vld_p1 ? main_p1 : '0;
    end

    assign bus.in_ready       = in_ready_p1;
    assign bus.out_valid      = vld_p1;
    assign bus.out_result     = shown_p1.result;
    assign bus.out_zero       = shown_p1.zero;
    assign bus.out_cout       = shown_p1.cout;
    assign bus.out_rd         = shown_p1.rd;
    assign bus.out_reg_write  = shown_p1.reg_write;
    assign bus.out_mem_read   = shown_p1.mem_read;
    assign bus.out_mem_write  = shown_p1.mem_write;
    assign bus.out_store_data = shown_p1.store_data;
    assign bus.redirect_valid = redirect_vld_p1;
    assign bus.redirect_pc    = redirect_vld_p1 ? redirect_pc_p1 : '0;
    assign bus.fwd_valid      = shown_p1.reg_write & ~shown_p1.mem_read & (shown_p1.rd != '0);
    assign bus.fwd_rd         = bus.fwd_valid ? shown_p1.rd : '0;
    assign bus.fwd_data       = bus.fwd_valid ? shown_p1.result : '0;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: streaming, backpressure, branches, flush, forwarding, reset.
module tb_ex_mem_stage;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    ex_mem_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

    ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [31:0] res, input logic z, input logic co,
                            input logic [4:0] rd, input logic rw, input logic mr,
                            input logic [1:0] bt, input logic [31:0] tgt);
        bus.in_valid      = 1'b1;
        bus.alu_result    = res;
        bus.alu_zero      = z;
        bus.alu_cout      = co;
        bus.rd_addr       = rd;
        bus.reg_write     = rw;
        bus.mem_read      = mr;
        bus.mem_write     = 1'b0;
        bus.store_data    = ~res;
        bus.branch_type   = bt;
        bus.branch_target = tgt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        set_beat(32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0);
        bus.in_valid = 1'b0;
        #12;
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.out_result !== 32'h0) $display("FAIL reset_out_result got %h exp 0", bus.out_result); else pass_cnt++;
        total_cnt++; if (bus.redirect_valid !== 1'b0) $display("FAIL reset_redirect got %b exp 0", bus.redirect_valid); else pass_cnt++;
        total_cnt++; if (bus.fwd_valid !== 1'b0) $display("FAIL reset_fwd_valid got %b exp 0", bus.fwd_valid); else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [31:0] v;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            v = i;
            set_beat(v, v[0], v[1], 5'd3, 1'b1, 1'b0, 2'b00, 32'h0);
            tick();
            total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_result !== v) $display("FAIL stream_result%0d got v=%b %h exp v=1 %h", i, bus.out_valid, bus.out_result, v); else pass_cnt++;
            total_cnt++; if (bus.out_zero !== v[0] || bus.out_cout !== v[1]) $display("FAIL stream_flags%0d got %b%b exp %b%b", i, bus.out_zero, bus.out_cout, v[0], v[1]); else pass_cnt++;
            total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL stream_in_ready%0d got %b exp 1", i, bus.in_ready); else pass_cnt++;
        end
        bus.in_valid = 1'b0;
        tick();
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL stream_drain got %b exp 0", bus.out_valid); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        set_beat(32'hA, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 2'b00, 32'h0);
        tick();
        total_cnt++; if (bus.out_result !== 32'hA || bus.in_ready !== 1'b1) $display("FAIL bp_first got %h rdy=%b exp a rdy=1", bus.out_result, bus.in_ready); else pass_cnt++;
        set_beat(32'hB, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 2'b00, 32'h0);
        tick();
        total_cnt++; if (bus.out_result !== 32'hA || bus.in_ready !== 1'b0) $display("FAIL bp_skid got %h rdy=%b exp a rdy=0", bus.out_result, bus.in_ready); else pass_cnt++;
        set_beat(32'hC, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 2'b00, 32'h0);
        tick();
        total_cnt++; if (bus.out_result !== 32'hA || bus.out_store_data !== ~32'hA) $display("FAIL bp_hold got %h exp a", bus.out_result); else pass_cnt++;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hA) $display("FAIL bp_order_a got %h exp a", bus.out_result); else pass_cnt++;
        tick();
        total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hB) $display("FAIL bp_order_b got %h exp b", bus.out_result); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_back got %b exp 1", bus.in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL bp_no_dup got %b exp 0", bus.out_valid); else pass_cnt++;
    endtask

    task automatic test_branch();
        bus.out_ready = 1'b1;
        set_beat(32'h10, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 2'b01, 32'h400);
        tick();
        total_cnt++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h400) $display("FAIL beq_taken got %b %h exp 1 00000400", bus.redirect_valid, bus.redirect_pc); else pass_cnt++;
        total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h10) $display("FAIL beq_beat got %h exp 10", bus.out_result); else pass_cnt++;
        set_beat(32'h11, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 2'b11, 32'h999);
        tick();
        total_cnt++; if (bus.redirect_valid !== 1'b0) $display("FAIL pulse_width got %b exp 0", bus.redirect_valid); else pass_cnt++;
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL wrong_path_drop got %b exp 0", bus.out_valid); else pass_cnt++;
        set_beat(32'h12, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 2'b01, 32'h500);
        tick();
        total_cnt++; if (bus.redirect_valid !== 1'b0 || bus.out_result !== 32'h12) $display("FAIL beq_not_taken got %b %h exp 0 12", bus.redirect_valid, bus.out_result); else pass_cnt++;
        set_beat(32'h13, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 2'b10, 32'h600);
        tick();
        total_cnt++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h600) $display("FAIL bne_taken got %b %h exp 1 00000600", bus.redirect_valid, bus.redirect_pc); else pass_cnt++;
        bus.in_valid = 1'b0;
        tick();
        total_cnt++; if (bus.redirect_valid !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL branch_idle got %b %b exp 0 0", bus.redirect_valid, bus.out_valid); else pass_cnt++;
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        set_beat(32'h21, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 2'b00, 32'h0);
        tick();
        set_beat(32'h22, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 2'b00, 32'h0);
        tick();
        total_cnt++; if (bus.in_ready !== 1'b0 || bus.out_result !== 32'h21) $display("FAIL flush_setup got rdy=%b %h exp rdy=0 21", bus.in_ready, bus.out_result); else pass_cnt++;
        set_beat(32'h23, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 2'b11, 32'h700);
        bus.flush = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        total_cnt++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL flush_clear got v=%b rdy=%b exp v=0 rdy=1", bus.out_valid, bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.redirect_valid !== 1'b0) $display("FAIL flush_redirect got %b exp 0", bus.redirect_valid); else pass_cnt++;
        tick();
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL flush_no_store got %b exp 0", bus.out_valid); else pass_cnt++;
        bus.out_ready = 1'b1;
        set_beat(32'h24, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 2'b00, 32'h0);
        tick();
        bus.in_valid = 1'b0;
        total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h24) $display("FAIL flush_recover got %h exp 24", bus.out_result); else pass_cnt++;
        tick();
    endtask

    task automatic test_forward();
        bus.out_ready = 1'b0;
        set_beat(32'hDEADBEEF, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 2'b00, 32'h0);
        tick();
        total_cnt++; if (bus.fwd_valid !== 1'b1 || bus.fwd_rd !== 5'd7 || bus.fwd_data !== 32'hDEADBEEF) $display("FAIL fwd_hit got %b %0d %h exp 1 7 deadbeef", bus.fwd_valid, bus.fwd_rd, bus.fwd_data); else pass_cnt++;
        bus.out_ready = 1'b1;
        set_beat(32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 2'b00, 32'h0);
        tick();
        total_cnt++; if (bus.out_valid !== 1'b1 || bus.fwd_valid !== 1'b0 || bus.fwd_data !== 32'h0 || bus.fwd_rd !== 5'd0) $display("FAIL fwd_rd0 got %b %h exp 0 0", bus.fwd_valid, bus.fwd_data); else pass_cnt++;
        set_beat(32'hDEADBEEF, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 2'b00, 32'h0);
        tick();
        total_cnt++; if (bus.out_mem_read !== 1'b1 || bus.fwd_valid !== 1'b0 || bus.fwd_data !== 32'h0) $display("FAIL fwd_load got mr=%b %b %h exp mr=1 0 0", bus.out_mem_read, bus.fwd_valid, bus.fwd_data); else pass_cnt++;
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        set_beat(32'h31, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 2'b00, 32'h0);
        tick();
        set_beat(32'h32, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 2'b00, 32'h0);
        tick();
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0 || bus.fwd_valid !== 1'b0) $display("FAIL arst_outputs got v=%b %h exp v=0 0", bus.out_valid, bus.out_result); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1 || bus.out_zero !== 1'b0 || bus.out_rd !== 5'd0) $display("FAIL arst_ctrl got rdy=%b z=%b rd=%0d exp 1 0 0", bus.in_ready, bus.out_zero, bus.out_rd); else pass_cnt++;
        #1 rst_n = 1'b1;
        tick();
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL arst_no_partial got %b exp 0", bus.out_valid); else pass_cnt++;
        bus.out_ready = 1'b1;
        set_beat(32'h33, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 2'b00, 32'h0);
        tick();
        bus.in_valid = 1'b0;
        total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h33) $display("FAIL arst_first_beat got %b %h exp 1 33", bus.out_valid, bus.out_result); else pass_cnt++;
        tick();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_flush();
        test_forward();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline stage directly downstream of the 32-bit combinational ALU.
- Captures the ALU result, zero flag and carry-out together with the instruction's control and destination fields.
- Resolves conditional branches from the zero flag and issues a PC redirect.
- Presents a forwarding bus back to the ALU operand muxes, and decouples the ALU from the memory stage with a valid/ready handshake and a 2-entry skid buffer.

Parameters:
- DATA_W, 32, datapath width (ALU result, store data, branch target).
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- alu_result  in  DATA_W  ALU Result.
- alu_zero  in  1  ALU Zero flag.
- alu_cout  in  1  ALU carry-out.
- rd_addr  in  REG_ADDR_W  destination register.
- reg_write  in  1  instruction writes rd.
- mem_read  in  1  load.
- mem_write  in  1  store.
- store_data  in  DATA_W  store operand.
- branch_type  in  2  00 none, 01 beq, 10 bne, 11 unconditional jump.
- branch_target  in  DATA_W  redirect address.
- flush  in  1  synchronous kill of all held beats.
- out_valid  out  1  beat available to MEM stage.
- out_ready  in  1  MEM stage accepts.
- out_result  out  DATA_W  held ALU result.
- out_zero  out  1  held Zero flag.
- out_cout  out  1  held carry-out.
- out_rd  out  REG_ADDR_W  held destination.
- out_reg_write  out  1  held control bit.
- out_mem_read  out  1  held control bit.
- out_mem_write  out  1  held control bit.
- out_store_data  out  DATA_W  held store operand.
- redirect_valid  out  1  one-cycle pulse, taken branch.
- redirect_pc  out  DATA_W  target accompanying redirect_valid.
- fwd_valid  out  1  forwarding bus valid.
- fwd_rd  out  REG_ADDR_W  forwarding register index.
- fwd_data  out  DATA_W  forwarding value.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs 0, except in_ready=1 one cycle after release (registered; reset value 1).
  - Main and skid entries invalid; redirect_valid=0.
- Storage: main entry drives the out_* ports; skid entry holds one beat while the main entry is stalled.
- in_ready is registered and equals "skid entry empty".
- Acceptance is in_valid & in_ready & !flush.
- Output transfer is out_valid & out_ready. out_valid = main valid. Output fields are stable while out_valid=1 and out_ready=0.
- On an accepted beat:
  - Main empty, or main transferring this cycle with skid empty: beat loads into main.
  - Otherwise: beat loads into skid, and in_ready drops next cycle.
- Skid full and main transfers: skid moves to main, skid empties, in_ready returns to 1 next cycle. The skid never overflows because in_ready=0 while it is full.
- Throughput is 1 beat/cycle with out_ready held high. Latency from accept to out_valid is 1 cycle.
- Branch resolution, evaluated on the accepted beat:
  - taken = (type 01 & alu_zero) | (type 10 & !alu_zero) | (type 11).
  - Next cycle: redirect_valid=1 for exactly one cycle and redirect_pc=branch_target.
  - The branch beat itself still enters the pipeline with its control bits as given.
- Wrong-path drop: any beat accepted in a cycle where redirect_valid=1 is discarded. It is not stored and produces no redirect.
- Flush:
  - Next edge clears main and skid valid, and redirect_valid.
  - No acceptance that cycle; in_ready=1 the following cycle.
  - Flush overrides a simultaneous accept and a simultaneous output transfer. A transfer shown in that cycle counts as completed downstream; MEM qualifies it with flush.
- Forwarding:
  - fwd_valid = main valid & out_reg_write & !out_mem_read & (out_rd != 0).
  - fwd_rd = out_rd; fwd_data = out_result.
  - Combinational from the main entry; fwd_data and fwd_rd are 0 when fwd_valid=0.
- Widths: all data pass through unmodified; no arithmetic is performed on DATA_W fields.
- Reset mid-stall discards all entries; no partial beat appears after reset.

Test Plan:
- Reset then stream 4 beats, out_ready=1: alu_result 0x1, 0x2, 0x3, 0x4 -> out_result 0x1..0x4 on consecutive cycles, starting 1 cycle after the first accept; in_ready stays 1.
- Backpressure: out_ready=0, send 0xA then 0xB:
  - out_result holds 0xA; in_ready=0 after the second accept.
  - Raise out_ready -> 0xA, then 0xB, in order.
  - in_ready=1 one cycle after skid drains; no beat lost or duplicated.
- Branch:
  - beq with alu_zero=1, target 0x400 -> redirect_valid=1 for 1 cycle with redirect_pc=0x400.
  - The beat accepted during that pulse is absent from the output.
  - beq with alu_zero=0 -> no redirect.
  - bne with alu_zero=0 -> redirect.
- Flush with main and skid full (out_ready=0) and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered beat is not stored.
- Forwarding:
  - reg_write=1, rd=7, result 0xDEADBEEF -> fwd_valid=1, fwd_rd=7, fwd_data=0xDEADBEEF.
  - Same beat with rd=0 or mem_read=1 -> fwd_valid=0, fwd_data=0.
- Async reset pulsed mid-stall (rst_n low between edges) -> all outputs 0 immediately; first beat after release appears normally with 1-cycle latency.
